pi_spi_master: RTL and testbench
================================

Name: pi_spi_master

Overview:
- SPI master driving the ss/spi_clk/mosi/miso link into the cart-side pi_io slave.
- Converts a host-side transaction request (read/write, address, length) into one framed SPI transfer and streams the data bytes through valid/ready ports.
- Sits in the MCU-side test and bridge logic: fifo polling, mdp register access, and bench stimulus for the audio/mdp path.

Parameters:
- CLK_DIV, 4, clk cycles per spi_clk half-period; minimum 1.
- LEN_W, 16, width of the byte-count field.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle transaction request; sampled only in IDLE.
- rw  in  1  1 = read, 0 = write; latched on accepted start.
- addr  in  24  PI byte address; latched on accepted start.
- len  in  LEN_W  data byte count; latched on accepted start.
- tx_data  in  8  write data byte.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  tx_data consumed this cycle.
- rx_data  out  8  read data byte.
- rx_valid  out  1  one-cycle pulse; rx_data valid; no backpressure.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at transaction end.
- ss  out  1  slave select, active-low.
- spi_clk  out  1  SPI clock; idles low.
- mosi  out  1  master out.
- miso  in  1  master in.

Behaviour:
- Reset (rst low at a clk edge), on the next cycle:
  - ss=1, spi_clk=0, mosi=0.
  - busy, done, tx_ready and rx_valid all 0; rx_data=0.
  - FSM returns to IDLE.
  - Reset mid-transfer aborts immediately; no done pulse.
- SPI mode 0, MSB first:
  - mosi changes only while spi_clk is low.
  - miso is sampled at the clk edge where spi_clk goes 0->1.
  - One bit takes 2*CLK_DIV clk cycles; one byte takes 16*CLK_DIV.
- Frame layout:
  - cmd byte {rw,7'h00}, then addr[23:16], addr[15:8], addr[7:0].
  - Read: one turnaround byte (mosi=0, miso ignored), then len bytes shifted with mosi=0.
  - Write: len bytes taken from tx_data.
- FSM states:
  - IDLE: start=1 latches fields, sets busy=1, drives ss=0, goes to SETUP.
  - SETUP: holds CLK_DIV cycles, then goes to HDR.
  - HDR: shifts 4 bytes. Next state: if len==0, END; else if rw, TURN; else DATA.
  - TURN: 1 byte, then DATA.
  - DATA: len bytes; decrements the counter per byte; goes to END at 0.
  - END: waits CLK_DIV cycles after the last falling edge, sets ss=1, pulses done, clears busy, returns to IDLE.
- start while busy: ignored, not queued.
- start and done in the same cycle: not possible, because IDLE is entered the cycle after done.
- Write data handshake:
  - tx_ready pulses one cycle when the shifter needs the next byte and tx_valid=1; the byte loads that cycle.
  - If tx_valid=0 at a byte boundary, the master stalls: spi_clk held low, ss held low, waiting indefinitely.
  - The first DATA byte is requested in the last HDR bit period, so no gap appears when tx_valid is already high.
- rx_valid: pulses the clk cycle after the 8th sampling edge of each read DATA byte. Never pulses for HDR or TURN bytes.
- len is unsigned; len=2^LEN_W-1 is legal. The counter does not wrap before END.
- Write tx_data bytes beyond len are never requested.

Optional Feature:
- Macro: PI_SS_GAP_EN.
- Defined: END holds ss=1 for a further 8*CLK_DIV cycles before done pulses and IDLE is entered. This guarantees the slave's frame-reset time between back-to-back transactions.
- Undefined: done pulses on the cycle ss rises; the minimum ss-high time is 1 clk cycle.

Decomposition:
- Shared package pi_spi_pkg:
  - state enum {IDLE, SETUP, HDR, TURN, DATA, END};
  - PI_CMD_RD = 8'h80, PI_CMD_WR = 8'h00;
  - PI_HDR_BYTES = 4.
- One sub-module, pi_spi_byte: 8-bit shift engine with CLK_DIV divider.
  - Inputs: load, din.
  - Outputs: byte_done, dout, spi_clk, mosi.
  - Samples miso.
- Top module holds the FSM, counters and handshakes.

Test Plan:
1. CLK_DIV=2, write addr=24'h12_3456, len=2, tx 8'hA5 then 8'h3C, tx_valid tied 1 -> mosi bytes 00,12,34,56,A5,3C. ss low about 6*32+4 cycles. Exactly 2 tx_ready pulses. One done.
2. Read addr=24'hFF_0000, len=3, slave returns 11,22,33 after turnaround -> cmd byte 80. 3 rx_valid pulses with rx_data 11,22,33. miso during TURN not reported.
3. Write len=2 with tx_valid dropped 50 cycles before byte 2 -> spi_clk frozen low, ss low for 50+ cycles; resumes on tx_valid; byte 2 correct.
4. len=0 write -> 4 header bytes, then done; no tx_ready, no rx_valid.
5. rst low during DATA byte 1 -> next cycle ss=1, spi_clk=0, busy=0, no done. A following start runs a clean frame.
6. Back-to-back starts with PI_SS_GAP_EN defined, CLK_DIV=2 -> ss high at least 16 cycles between frames. With the macro undefined -> ss high at least 1 cycle. start pulses during busy ignored.

Source files
------------

// File: rtl/pi_spi_pkg.sv
// Shared types and constants for the pi_io SPI master: FSM states, command
// bytes and the header byte selector.
package pi_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HDR   = 3'd2,
    TURN  = 3'd3,
    DATA  = 3'd4,
    END   = 3'd5
  } state_e;

  localparam logic [7:0] PI_CMD_RD    = 8'h80;
  localparam logic [7:0] PI_CMD_WR    = 8'h00;
  localparam int         PI_HDR_BYTES = 4;

  // Header byte idx of the frame: cmd, then the address MSB first.
  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic rd,
                                          input logic [23:0] a);
    logic [7:0] b;
    case (idx)
      2'd0:    b = rd ? PI_CMD_RD : PI_CMD_WR;
      2'd1:    b = a[23:16];
      2'd2:    b = a[15:8];
      default: b = a[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pi_spi_byte.sv
// Mode-0 byte shifter: drives spi_clk/mosi MSB first from a loaded byte and
// samples miso on each rising spi_clk edge; CLK_DIV clk cycles per half-period.
module pi_spi_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       miso,
  output logic       byte_done,
  output logic       last_rise,
  output logic [7:0] dout,
  output logic       spi_clk,
  output logic       mosi
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          active_r;
  logic          sclk_r;
  logic          mosi_r;
  logic [DW-1:0] div_r;
  logic [2:0]    bit_r;
  logic [7:0]    tx_r;
  logic [7:0]    rx_r;
  logic          tick_s;

  // byte_done marks the final falling edge so a new byte can load without a gap
  always_comb begin
    tick_s    = active_r && (div_r == DW'(CLK_DIV - 1));
    byte_done = tick_s && sclk_r && (bit_r == 3'd7);
    last_rise = tick_s && !sclk_r && (bit_r == 3'd7);
  end

  assign dout    = rx_r;
  assign spi_clk = sclk_r;
  assign mosi    = mosi_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      active_r <= 1'b0;
      sclk_r   <= 1'b0;
      mosi_r   <= 1'b0;
      div_r    <= '0;
      bit_r    <= 3'd0;
      tx_r     <= 8'h00;
      rx_r     <= 8'h00;
    end else if (load && (!active_r || byte_done)) begin
      active_r <= 1'b1;
      sclk_r   <= 1'b0;
      mosi_r   <= din[7];
      div_r    <= '0;
      bit_r    <= 3'd0;
      tx_r     <= din;
    end else if (tick_s) begin
      div_r <= '0;
      if (!sclk_r) begin
        sclk_r <= 1'b1;
        rx_r   <= {rx_r[6:0], miso};
      end else begin
        sclk_r <= 1'b0;
        if (bit_r == 3'd7) begin
          active_r <= 1'b0;
          mosi_r   <= 1'b0;
        end else begin
          bit_r  <= bit_r + 3'd1;
          tx_r   <= {tx_r[6:0], 1'b0};
          mosi_r <= tx_r[6];
        end
      end
    end else if (active_r) begin
      div_r <= div_r + DW'(1);
    end
  end

endmodule

// File: rtl/pi_spi_master.sv
// SPI master framing host read/write requests for the pi_io slave.
// Optional PI_SS_GAP_EN: hold ss high a further 8*CLK_DIV cycles before done.
module pi_spi_master
  import pi_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             ss,
  output logic             spi_clk,
  output logic             mosi,
  input  logic             miso
);

  localparam int END_RISE = CLK_DIV - 1;
`ifdef PI_SS_GAP_EN
  localparam int END_DONE = 9 * CLK_DIV - 1;
`else
  localparam int END_DONE = CLK_DIV - 1;
`endif
  localparam int TW = $clog2(9 * CLK_DIV) + 1;

  state_e           state_r;
  state_e           state_nx;
  logic [TW-1:0]    timer_r;
  logic [1:0]       hdr_cnt_r;
  logic [LEN_W-1:0] cnt_r;
  logic             rw_r;
  logic [23:0]      addr_r;
  logic             wait_tx_r;
  logic             fin_r;
  logic             ss_r;
  logic             busy_r;
  logic             done_r;
  logic             rx_valid_r;
  logic [7:0]       rx_data_r;

  logic             byte_done_s;
  logic             last_rise_s;
  logic [7:0]       dout_s;
  logic             load_s;
  logic [7:0]       din_s;
  logic             need_tx_s;
  logic             tx_ready_s;
  logic             dec_s;
  logic             hdr_last_s;
  logic             cnt_zero_s;
  logic             setup_end_s;

  assign hdr_last_s  = (hdr_cnt_r == 2'(PI_HDR_BYTES - 1));
  assign cnt_zero_s  = (cnt_r == '0);
  assign setup_end_s = (timer_r == TW'(CLK_DIV - 1));

  pi_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .din       (din_s),
    .miso      (miso),
    .byte_done (byte_done_s),
    .last_rise (last_rise_s),
    .dout      (dout_s),
    .spi_clk   (spi_clk),
    .mosi      (mosi)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:  if (start) state_nx = SETUP; else state_nx = IDLE;
      SETUP: if (setup_end_s) state_nx = HDR; else state_nx = SETUP;
      HDR: begin
        if (byte_done_s && hdr_last_s) begin
          if (cnt_zero_s)  state_nx = END;
          else if (rw_r)   state_nx = TURN;
          else             state_nx = DATA;
        end else begin
          state_nx = HDR;
        end
      end
      TURN:  if (byte_done_s) state_nx = DATA; else state_nx = TURN;
      DATA:  if (byte_done_s && cnt_zero_s) state_nx = END; else state_nx = DATA;
      END:   if (fin_r) state_nx = IDLE; else state_nx = END;
      default: state_nx = IDLE;
    endcase
  end

  // shifter loads and the write-data handshake
  always_comb begin
    load_s     = 1'b0;
    din_s      = 8'h00;
    need_tx_s  = 1'b0;
    tx_ready_s = 1'b0;
    case (state_r)
      SETUP: begin
        if (setup_end_s) begin
          load_s = 1'b1;
          din_s  = hdr_byte(2'd0, rw_r, addr_r);
        end else begin
          load_s = 1'b0;
        end
      end
      HDR: begin
        if (byte_done_s && !hdr_last_s) begin
          load_s = 1'b1;
          din_s  = hdr_byte(hdr_cnt_r + 2'd1, rw_r, addr_r);
        end else if (byte_done_s && !cnt_zero_s) begin
          load_s    = rw_r;
          need_tx_s = !rw_r;
        end else begin
          load_s = 1'b0;
        end
      end
      TURN: load_s = byte_done_s;
      DATA: begin
        if ((byte_done_s || wait_tx_r) && !cnt_zero_s) begin
          load_s    = rw_r;
          need_tx_s = !rw_r;
        end else begin
          load_s = 1'b0;
        end
      end
      default: load_s = 1'b0;
    endcase
    if (need_tx_s && tx_valid) begin
      load_s     = 1'b1;
      din_s      = tx_data;
      tx_ready_s = 1'b1;
    end else begin
      tx_ready_s = 1'b0;
    end
    dec_s = load_s && ((state_r == DATA) || (state_r == TURN) ||
                       ((state_r == HDR) && hdr_last_s && !rw_r));
  end

  // frame fields, counters, ss and host-side outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer_r    <= '0;
      hdr_cnt_r  <= 2'd0;
      cnt_r      <= '0;
      rw_r       <= 1'b0;
      addr_r     <= 24'h000000;
      wait_tx_r  <= 1'b0;
      fin_r      <= 1'b0;
      ss_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'h00;
    end else begin
      done_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      if ((state_nx == state_r) && ((state_r == SETUP) || (state_r == END)))
        timer_r <= timer_r + TW'(1);
      else
        timer_r <= '0;
      if ((state_r == IDLE) && start) begin
        rw_r      <= rw;
        addr_r    <= addr;
        cnt_r     <= len;
        hdr_cnt_r <= 2'd0;
        wait_tx_r <= 1'b0;
        fin_r     <= 1'b0;
        busy_r    <= 1'b1;
        ss_r      <= 1'b0;
      end
      if ((state_r == HDR) && byte_done_s)
        hdr_cnt_r <= hdr_cnt_r + 2'd1;
      if (dec_s)
        cnt_r <= cnt_r - LEN_W'(1);
      if (need_tx_s)
        wait_tx_r <= !tx_valid;
      if ((state_r == DATA) && rw_r && last_rise_s) begin
        rx_valid_r <= 1'b1;
        rx_data_r  <= {dout_s[6:0], miso};
      end
      // ss rises CLK_DIV cycles after the last fall; done may wait for the gap
      if ((state_r == END) && !fin_r) begin
        if (timer_r == TW'(END_RISE))
          ss_r <= 1'b1;
        if (timer_r == TW'(END_DONE)) begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          fin_r  <= 1'b1;
        end
      end
    end
  end

  assign tx_ready = tx_ready_s;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign ss       = ss_r;

endmodule

// File: tb/tb_pi_spi_master.sv
// Table-driven bench for pi_spi_master: an SPI slave model captures mosi and
// returns miso, and frames are checked against bytes derived from the request.
module tb_pi_spi_master;

  localparam int CD = 2;
  localparam int LW = 16;
  localparam int NV = 14;
`ifdef PI_SS_GAP_EN
  localparam int MIN_GAP = 8 * CD;
`else
  localparam int MIN_GAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          rw = 1'b0;
  logic [23:0]   addr = 24'h0;
  logic [LW-1:0] len = '0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          miso = 1'b0;
  logic          tx_ready, rx_valid, busy, done, ss, spi_clk, mosi;
  logic [7:0]    rx_data;

  always #5 clk = ~clk;

  pi_spi_master #(.CLK_DIV(CD), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .len(len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .ss(ss), .spi_clk(spi_clk), .mosi(mosi), .miso(miso)
  );

  typedef struct {
    logic            rw_i;
    logic [23:0]     addr_i;
    int              len_i;
    bit              stall_i;
    logic [7:0][7:0] data_i;
    int              exp_bytes;
    int              exp_txr;
    int              exp_rxv;
    logic [7:0]      exp_cmd;
  } vec_t;

  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_bad = 0;
  int   hi_run = 0;
  int   last_gap = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic r, input logic [23:0] a, input int l,
                         input bit st, input int eb, input int et, input int er,
                         input logic [7:0] ec);
    vecs[i].rw_i = r;   vecs[i].addr_i = a;   vecs[i].len_i = l;   vecs[i].stall_i = st;
    for (int k = 0; k < 8; k++) vecs[i].data_i[k] = 8'($urandom);
    vecs[i].exp_bytes = eb; vecs[i].exp_txr = et; vecs[i].exp_rxv = er; vecs[i].exp_cmd = ec;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] expq[$];
    logic [7:0] got[$];
    logic [7:0] slv[$];
    logic [7:0] sh, sb;
    logic       psclk, pmosi;
    bit         took, accepted, rise;
    int         sbit, txr, rxv, dn, ss_low, vio, lowrun, maxlow, tx_idx, stall_left, nom;
    sbit = 0; txr = 0; rxv = 0; dn = 0; ss_low = 0; vio = 0; lowrun = 0; maxlow = 0;
    tx_idx = 0; stall_left = 0; accepted = 0; sh = 8'h00;
    // expected mosi stream: cmd, addr MSB first, then turnaround and data
    expq.push_back(v.rw_i ? 8'h80 : 8'h00);
    expq.push_back(v.addr_i[23:16]);
    expq.push_back(v.addr_i[15:8]);
    expq.push_back(v.addr_i[7:0]);
    if (v.len_i > 0) begin
      if (v.rw_i) expq.push_back(8'h00);
      for (int k = 0; k < v.len_i; k++) expq.push_back(v.rw_i ? 8'h00 : v.data_i[k]);
    end
    for (int k = 0; k < expq.size(); k++)
      slv.push_back((v.rw_i && k >= 5) ? v.data_i[k-5] : 8'($urandom));
    @(posedge clk); #1;
    rw = v.rw_i; addr = v.addr_i; len = LW'(v.len_i); start = 1'b1; tx_valid = 1'b1;
    tx_data = (v.len_i > 0) ? v.data_i[0] : 8'($urandom);
    sb = slv[0]; miso = sb[7];
    psclk = spi_clk; pmosi = mosi;
    for (int cyc = 0; cyc < 3000 && dn == 0; cyc++) begin
      @(negedge clk);
      rise = !psclk && spi_clk;
      if (spi_clk && (mosi !== pmosi)) vio++;
      if (ss && spi_clk) vio++;
      if (ss) hi_run++;
      else begin
        if (hi_run > 0) last_gap = hi_run;
        hi_run = 0;
        ss_low++;
        if (rise) begin
          sh = {sh[6:0], mosi};
          sbit++;
          if (sbit % 8 == 0) got.push_back(sh);
        end
        if (!spi_clk) begin
          lowrun++;
          if (lowrun > maxlow) maxlow = lowrun;
        end else lowrun = 0;
      end
      took = tx_ready;
      if (tx_ready) txr++;
      if (rx_valid) begin
        chk("rx_data", {24'h0, rx_data}, {24'h0, (rxv < v.len_i) ? v.data_i[rxv] : 8'hxx});
        chk("rx_valid_after_8th_rise", 32'(rise && (sbit % 8 == 0) && (sbit / 8 >= 6)), 32'd1);
        rxv++;
      end
      if (done) begin
        dn++;
        chk("ss_high_at_done", {31'h0, ss}, 32'd1);
        chk("busy_low_at_done", {31'h0, busy}, 32'd0);
      end
      if (busy) accepted = 1;
      if (sbit / 8 < slv.size()) begin
        sb = slv[sbit/8];
        miso = sb[7 - sbit % 8];
      end else miso = 1'b0;
      psclk = spi_clk; pmosi = mosi;
      @(posedge clk); #1;
      if (accepted) begin
        // a start while busy must be ignored; the other fields change too
        start = (cyc == 20);
        if (cyc == 20) begin rw = ~v.rw_i; addr = 24'($urandom); len = LW'($urandom); end
      end
      if (took) begin
        tx_idx++;
        tx_data = (tx_idx < v.len_i) ? v.data_i[tx_idx] : 8'($urandom);
        if (v.stall_i && tx_idx == 1) stall_left = 50;
      end
      if (stall_left > 0) begin tx_valid = 1'b0; stall_left--; end
      else tx_valid = 1'b1;
    end
    start = 1'b0;
    chk("done_pulse_seen", 32'(dn), 32'd1);
    chk("frame_byte_count", 32'(got.size()), 32'(v.exp_bytes));
    for (int k = 0; k < expq.size(); k++)
      chk("mosi_byte", {24'h0, (k < got.size()) ? got[k] : 8'hxx}, {24'h0, expq[k]});
    chk("cmd_byte", {24'h0, (got.size() > 0) ? got[0] : 8'hxx}, {24'h0, v.exp_cmd});
    chk("tx_ready_count", 32'(txr), 32'(v.exp_txr));
    chk("rx_valid_count", 32'(rxv), 32'(v.exp_rxv));
    chk("mosi_or_sclk_rule_violations", 32'(vio), 32'd0);
    chk("ss_gap_before_frame", 32'(last_gap >= MIN_GAP), 32'd1);
    nom = CD * (2 + 16 * v.exp_bytes);
    if (v.stall_i) begin
      chk("ss_low_stretched_by_stall", 32'(ss_low >= nom + 16), 32'd1);
      chk("spi_clk_frozen_during_stall", 32'(maxlow >= 16), 32'd1);
    end else begin
      chk("ss_low_cycles", 32'(ss_low), 32'(nom));
      chk("spi_clk_low_run", 32'(maxlow <= 2 * CD), 32'd1);
    end
  endtask

  task automatic reset_seq();
    int dn, sl;
    dn = 0; sl = 0;
    @(posedge clk); #1;
    rw = 1'b0; addr = 24'hABCDEF; len = LW'(3); start = 1'b1; tx_valid = 1'b1;
    tx_data = 8'h5A;
    @(posedge clk); #1 start = 1'b0;
    repeat (148) @(posedge clk);
    @(negedge clk);
    chk("frame_active_before_rst", {31'h0, ss}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_ss", {31'h0, ss}, 32'd1);
    chk("abort_spi_clk", {31'h0, spi_clk}, 32'd0);
    chk("abort_mosi", {31'h0, mosi}, 32'd0);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_tx_ready", {31'h0, tx_ready}, 32'd0);
    chk("abort_rx_valid", {31'h0, rx_valid}, 32'd0);
    chk("abort_rx_data", {24'h0, rx_data}, 32'd0);
    hi_run = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) dn++;
      if (!ss || spi_clk) sl++;
      if (ss) hi_run++;
    end
    chk("no_done_after_abort", 32'(dn), 32'd0);
    chk("link_idle_after_abort", 32'(sl), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ss", {31'h0, ss}, 32'd1);
    chk("rst_spi_clk", {31'h0, spi_clk}, 32'd0);
    chk("rst_mosi", {31'h0, mosi}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_tx_ready", {31'h0, tx_ready}, 32'd0);
    chk("rst_rx_valid", {31'h0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'h0, rx_data}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    hi_run = 2;

    set_vec(0, 1'b0, 24'h123456, 2, 1'b0, 6, 2, 0, 8'h00);
    vecs[0].data_i[0] = 8'hA5; vecs[0].data_i[1] = 8'h3C;
    set_vec(1, 1'b1, 24'hFF0000, 3, 1'b0, 8, 0, 3, 8'h80);
    vecs[1].data_i[0] = 8'h11; vecs[1].data_i[1] = 8'h22; vecs[1].data_i[2] = 8'h33;
    set_vec(2, 1'b0, 24'h00A0B0, 2, 1'b1, 6, 2, 0, 8'h00);
    set_vec(3, 1'b0, 24'h7E0001, 0, 1'b0, 4, 0, 0, 8'h00);
    set_vec(4, 1'b1, 24'h000102, 0, 1'b0, 4, 0, 0, 8'h80);
    set_vec(5, 1'b1, 24'hC0FFEE, 1, 1'b0, 6, 0, 1, 8'h80);
    for (int i = 6; i < NV; i++) begin
      logic r;
      int   l;
      r = 1'($urandom);
      l = int'($urandom_range(0, 5));
      set_vec(i, r, 24'($urandom), l, 1'b0,
              4 + ((l > 0) ? (l + (r ? 1 : 0)) : 0),
              r ? 0 : l, r ? l : 0, r ? 8'h80 : 8'h00);
    end

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i]);
      if (i == 5) reset_seq();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
